// File: rtl/axis_arb_pkg.sv
// Shared definitions for the AXI4-Stream video source arbiter.
// Contents:
//   arb_state_e          - arbiter FSM states (IDLE, PASS, DRAIN)
//   MODE_*               - cfg_mode encodings for the grant policy
//   DEFAULT_FRAME_PIXELS - nominal beats per frame (640x480)
package axis_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    localparam logic [1:0] MODE_FIX0  = 2'd0;
    localparam logic [1:0] MODE_FIX1  = 2'd1;
    localparam logic [1:0] MODE_RR    = 2'd2;
    localparam logic [1:0] MODE_PRIO0 = 2'd3;

    localparam int DEFAULT_FRAME_PIXELS = 307200;

endpackage

// File: rtl/frame_len_checker.sv
// Pixel counter for the frame currently being forwarded.
// Ports:
//   clk, rstn    - pixel clock, asynchronous active-low reset
//   beat_i       - a beat was forwarded to the sink this cycle
//   tlast_i      - the granted source flagged end of frame on that beat
//   last_beat_o  - the current beat is the nominal final beat of the frame
//   short_o      - frame ended (tlast) before the nominal length
//   long_o       - nominal length reached without tlast
// The counter returns to zero on any frame end, so a following DRAIN
// phase and the next frame both start from a clean count.
module frame_len_checker #(
    parameter int FRAME_PIXELS = 16,
    parameter int CNT_W        = $clog2(FRAME_PIXELS)
) (
    input  logic clk,
    input  logic rstn,
    input  logic beat_i,
    input  logic tlast_i,
    output logic last_beat_o,
    output logic short_o,
    output logic long_o
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PIXELS - 1);

    logic [CNT_W-1:0] pix_cnt_q;
    logic [CNT_W-1:0] pix_cnt_d;

    assign last_beat_o = (pix_cnt_q == LAST_IDX);
    assign short_o     = beat_i & tlast_i & ~last_beat_o;
    assign long_o      = beat_i & ~tlast_i & last_beat_o;

    // Next pixel count: advance per beat, restart at any frame end.
    always_comb begin
        pix_cnt_d = pix_cnt_q;
        if (beat_i) begin
            if (tlast_i || last_beat_o) begin
                pix_cnt_d = '0;
            end else begin
                pix_cnt_d = pix_cnt_q + CNT_W'(1);
            end
        end else begin
            pix_cnt_d = pix_cnt_q;
        end
    end

    // Pixel counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pix_cnt_q <= '0;
        end else begin
            pix_cnt_q <= pix_cnt_d;
        end
    end

endmodule

// File: rtl/axis_video_source_arbiter.sv
// Frame-granular arbiter sharing one HDMI AXI4-Stream sink between two
// video sources. Grants change only between frames; the forwarded frame
// is cut to FRAME_PIXELS beats (remainder drained) and short frames are
// flagged.
// Ports:
//   clk_25MHZ, rstn            - pixel clock, async active-low reset
//   s0_*, s1_*                 - source streams (tdata/tvalid/tlast/tready)
//   m_*                        - stream to the HDMI sink
//   cfg_enable, cfg_mode       - arbitration enable and grant policy
//   err_clr                    - clears the sticky error flags
//   grant, busy, frame_cnt     - status: granted source, frame in flight,
//                                completed frames forwarded
//   err_short, err_long        - sticky frame length errors
module axis_video_source_arbiter
    import axis_arb_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int FRAME_PIXELS = DEFAULT_FRAME_PIXELS,
    parameter int CNT_W        = $clog2(FRAME_PIXELS)
) (
    input  logic              clk_25MHZ,
    input  logic              rstn,
    input  logic [DATA_W-1:0] s0_tdata,
    input  logic              s0_tvalid,
    input  logic              s0_tlast,
    output logic              s0_tready,
    input  logic [DATA_W-1:0] s1_tdata,
    input  logic              s1_tvalid,
    input  logic              s1_tlast,
    output logic              s1_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    output logic              m_tlast,
    input  logic              m_tready,
    input  logic              cfg_enable,
    input  logic [1:0]        cfg_mode,
    input  logic              err_clr,
    output logic              grant,
    output logic              busy,
    output logic [15:0]       frame_cnt,
    output logic              err_short,
    output logic              err_long
);

    arb_state_e  state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_served_q, last_served_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        err_short_q, err_short_d;
    logic        err_long_q, err_long_d;

    logic [DATA_W-1:0] sel_tdata;
    logic              sel_tvalid;
    logic              sel_tlast;
    logic [1:0]        src_valid;
    logic              pick_valid;
    logic              pick_src;
    logic              pass_beat;
    logic              last_beat;
    logic              len_short;
    logic              len_long;

    assign src_valid = {s1_tvalid, s0_tvalid};
    assign pass_beat = (state_q == PASS) & sel_tvalid & m_tready;

    // Route the granted source onto a common set of signals.
    always_comb begin
        if (grant_q) begin
            sel_tdata  = s1_tdata;
            sel_tvalid = s1_tvalid;
            sel_tlast  = s1_tlast;
        end else begin
            sel_tdata  = s0_tdata;
            sel_tvalid = s0_tvalid;
            sel_tlast  = s0_tlast;
        end
    end

    // Grant policy evaluated while idle; round-robin prefers the source
    // that was not served last.
    always_comb begin
        pick_valid = 1'b0;
        pick_src   = 1'b0;
        case (cfg_mode)
            MODE_FIX0: begin
                pick_valid = s0_tvalid;
                pick_src   = 1'b0;
            end
            MODE_FIX1: begin
                pick_valid = s1_tvalid;
                pick_src   = 1'b1;
            end
            MODE_RR: begin
                if (src_valid[~last_served_q]) begin
                    pick_valid = 1'b1;
                    pick_src   = ~last_served_q;
                end else if (src_valid[last_served_q]) begin
                    pick_valid = 1'b1;
                    pick_src   = last_served_q;
                end else begin
                    pick_valid = 1'b0;
                end
            end
            default: begin
                pick_valid = s0_tvalid | s1_tvalid;
                pick_src   = ~s0_tvalid;
            end
        endcase
    end

    frame_len_checker #(
        .FRAME_PIXELS (FRAME_PIXELS),
        .CNT_W        (CNT_W)
    ) u_len_chk (
        .clk         (clk_25MHZ),
        .rstn        (rstn),
        .beat_i      (pass_beat),
        .tlast_i     (sel_tlast),
        .last_beat_o (last_beat),
        .short_o     (len_short),
        .long_o      (len_long)
    );

    // FSM next state, stream muxing and status updates.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_served_d = last_served_q;
        frame_cnt_d   = frame_cnt_q;
        m_tdata       = '0;
        m_tvalid      = 1'b0;
        m_tlast       = 1'b0;
        s0_tready     = 1'b0;
        s1_tready     = 1'b0;
        // Clear first so an error event in the same cycle overrides it.
        if (err_clr) begin
            err_short_d = 1'b0;
            err_long_d  = 1'b0;
        end else begin
            err_short_d = err_short_q;
            err_long_d  = err_long_q;
        end
        case (state_q)
            IDLE: begin
                if (cfg_enable && pick_valid) begin
                    grant_d = pick_src;
                    state_d = PASS;
                end else begin
                    state_d = IDLE;
                end
            end
            PASS: begin
                m_tdata  = sel_tdata;
                m_tvalid = sel_tvalid;
                // Nominal last beat is always marked so the sink never
                // sees an over-long frame.
                m_tlast  = sel_tlast | last_beat;
                if (grant_q) begin
                    s1_tready = m_tready;
                end else begin
                    s0_tready = m_tready;
                end
                if (pass_beat && sel_tlast) begin
                    frame_cnt_d   = frame_cnt_q + 16'd1;
                    last_served_d = grant_q;
                    state_d       = IDLE;
                    if (len_short) begin
                        err_short_d = 1'b1;
                    end else begin
                        err_short_d = err_short_d;
                    end
                end else if (len_long) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    err_long_d  = 1'b1;
                    state_d     = DRAIN;
                end else begin
                    state_d = PASS;
                end
            end
            DRAIN: begin
                if (grant_q) begin
                    s1_tready = 1'b1;
                end else begin
                    s0_tready = 1'b1;
                end
                if (sel_tvalid && sel_tlast) begin
                    last_served_d = grant_q;
                    state_d       = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and status registers.
    always_ff @(posedge clk_25MHZ or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            grant_q       <= 1'b0;
            last_served_q <= 1'b1;
            frame_cnt_q   <= 16'd0;
            err_short_q   <= 1'b0;
            err_long_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_served_q <= last_served_d;
            frame_cnt_q   <= frame_cnt_d;
            err_short_q   <= err_short_d;
            err_long_q    <= err_long_d;
        end
    end

    assign grant     = grant_q;
    assign busy      = (state_q != IDLE);
    assign frame_cnt = frame_cnt_q;
    assign err_short = err_short_q;
    assign err_long  = err_long_q;

endmodule

// File: tb/tb_axis_video_source_arbiter.sv
// Randomized bench for axis_video_source_arbiter with FRAME_PIXELS = 16.
// A transaction-level reference model (frame in flight, dropping flag,
// beat count, served history) predicts every output each cycle.
module tb_axis_video_source_arbiter;

    localparam int FP = 16;
    localparam int DW = 32;

    logic          clk;
    logic          rstn;
    logic [DW-1:0] s0_tdata, s1_tdata, m_tdata;
    logic          s0_tvalid, s0_tlast, s0_tready;
    logic          s1_tvalid, s1_tlast, s1_tready;
    logic          m_tvalid, m_tlast, m_tready;
    logic          cfg_enable;
    logic [1:0]    cfg_mode;
    logic          err_clr;
    logic          grant, busy, err_short, err_long;
    logic [15:0]   frame_cnt;

    axis_video_source_arbiter #(
        .DATA_W       (DW),
        .FRAME_PIXELS (FP)
    ) dut (
        .clk_25MHZ  (clk),
        .rstn       (rstn),
        .s0_tdata   (s0_tdata),
        .s0_tvalid  (s0_tvalid),
        .s0_tlast   (s0_tlast),
        .s0_tready  (s0_tready),
        .s1_tdata   (s1_tdata),
        .s1_tvalid  (s1_tvalid),
        .s1_tlast   (s1_tlast),
        .s1_tready  (s1_tready),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tlast    (m_tlast),
        .m_tready   (m_tready),
        .cfg_enable (cfg_enable),
        .cfg_mode   (cfg_mode),
        .err_clr    (err_clr),
        .grant      (grant),
        .busy       (busy),
        .frame_cnt  (frame_cnt),
        .err_short  (err_short),
        .err_long   (err_long)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Source generators: each source walks through frames of chosen length.
    logic [DW-1:0] sd [2];
    logic          sv [2];
    logic          sl [2];
    int            s_len [2];
    int            s_idx [2];
    bit            acc [2];
    bit            rst_seen;
    int            p_valid [2];
    int            len_kind [2];
    int            rdy_pct, clr_pct, rst_pm, rst_hold;

    assign s0_tdata = sd[0]; assign s0_tvalid = sv[0]; assign s0_tlast = sl[0];
    assign s1_tdata = sd[1]; assign s1_tvalid = sv[1]; assign s1_tlast = sl[1];

    // Reference model.
    bit mdl_active, mdl_drop;
    int mdl_src, mdl_prev, mdl_beats, mdl_frames;
    bit mdl_es, mdl_el;

    function automatic int pick_len(input int kind);
        int r;
        if (kind == 0) return FP;
        if (kind == 1) begin
            r = $urandom_range(0, 9);
            if (r < 6) return FP;
            if (r < 8) return $urandom_range(1, FP - 1);
            return $urandom_range(FP + 1, FP + 6);
        end
        return kind;
    endfunction

    // Monitor: predict and compare mid-cycle, then advance the model.
    initial begin
        logic          v, l;
        logic [DW-1:0] d;
        logic [1:0]    er, avail;
        bit            ev;
        int            pick;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                check_eq("rst_m_tvalid", m_tvalid, 1'b0);
                check_eq("rst_m_tlast", m_tlast, 1'b0);
                check_eq("rst_m_tdata", m_tdata, '0);
                check_eq("rst_treadys", {s1_tready, s0_tready}, 2'b00);
                check_eq("rst_status", {grant, busy, err_short, err_long}, 4'b0000);
                check_eq("rst_frame_cnt", frame_cnt, 16'd0);
                mdl_active = 0; mdl_drop = 0; mdl_src = 0; mdl_prev = 1;
                mdl_beats = 0; mdl_frames = 0; mdl_es = 0; mdl_el = 0;
                acc[0] = 0; acc[1] = 0;
                rst_seen = 1;
            end else begin
                v = (mdl_src == 1) ? s1_tvalid : s0_tvalid;
                l = (mdl_src == 1) ? s1_tlast  : s0_tlast;
                d = (mdl_src == 1) ? s1_tdata  : s0_tdata;
                er = 2'b00;
                if (mdl_active) er[mdl_src] = mdl_drop ? 1'b1 : m_tready;
                ev = mdl_active && !mdl_drop && v;
                check_eq("m_tvalid", m_tvalid, ev);
                check_eq("s0_tready", s0_tready, er[0]);
                check_eq("s1_tready", s1_tready, er[1]);
                check_eq("grant", grant, 64'(mdl_src));
                check_eq("busy", busy, mdl_active);
                check_eq("frame_cnt", frame_cnt, 64'(mdl_frames & 16'hFFFF));
                check_eq("err_short", err_short, mdl_es);
                check_eq("err_long", err_long, mdl_el);
                if (ev) begin
                    check_eq("m_tdata", m_tdata, d);
                    check_eq("m_tlast", m_tlast, l || (mdl_beats == FP - 1));
                end
                acc[0] = s0_tvalid && er[0];
                acc[1] = s1_tvalid && er[1];
                if (err_clr) begin mdl_es = 0; mdl_el = 0; end
                if (!mdl_active) begin
                    avail = {s1_tvalid, s0_tvalid};
                    pick = -1;
                    if (cfg_enable) begin
                        case (cfg_mode)
                            2'd0: if (avail[0]) pick = 0;
                            2'd1: if (avail[1]) pick = 1;
                            2'd2: if (avail[1 - mdl_prev]) pick = 1 - mdl_prev;
                                  else if (avail[mdl_prev]) pick = mdl_prev;
                            default: if (avail[0]) pick = 0; else if (avail[1]) pick = 1;
                        endcase
                    end
                    if (pick >= 0) begin
                        mdl_active = 1; mdl_src = pick; mdl_beats = 0;
                    end
                end else if (!mdl_drop) begin
                    if (v && m_tready) begin
                        if (l) begin
                            mdl_frames++;
                            if (mdl_beats < FP - 1) mdl_es = 1;
                            mdl_active = 0; mdl_prev = mdl_src;
                        end else if (mdl_beats == FP - 1) begin
                            mdl_frames++; mdl_el = 1; mdl_drop = 1; mdl_beats = 0;
                        end else begin
                            mdl_beats++;
                        end
                    end
                end else if (v && l) begin
                    mdl_active = 0; mdl_drop = 0; mdl_prev = mdl_src;
                end
            end
        end
    end

    // One clock of stimulus, driven just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (rst_seen) begin
                s_idx[i] = 0; s_len[i] = pick_len(len_kind[i]); sv[i] = 1'b0;
            end else if (acc[i]) begin
                sv[i] = 1'b0;
                if (sl[i]) begin
                    s_idx[i] = 0; s_len[i] = pick_len(len_kind[i]);
                end else begin
                    s_idx[i]++;
                end
            end
            if (!sv[i] && ($urandom_range(0, 99) < p_valid[i])) begin
                sv[i] = 1'b1;
                sd[i] = $urandom;
                sl[i] = (s_idx[i] == s_len[i] - 1);
            end
        end
        rst_seen = 0;
        m_tready = ($urandom_range(0, 99) < rdy_pct);
        err_clr  = ($urandom_range(0, 99) < clr_pct);
        if (rst_pm > 0 && $urandom_range(0, 999) < rst_pm) rst_hold = 2;
        if (rst_hold > 0) begin
            rstn = 1'b0; rst_hold--;
        end else begin
            rstn = 1'b1;
        end
    endtask

    task automatic phase(input int mode, input bit en, input int p0, input int p1,
                         input int k0, input int k1, input int rdy, input int clr,
                         input int rpm, input int n);
        cfg_mode = 2'(mode); cfg_enable = en;
        p_valid[0] = p0; p_valid[1] = p1; len_kind[0] = k0; len_kind[1] = k1;
        rdy_pct = rdy; clr_pct = clr; rst_pm = rpm;
        repeat (n) step();
    endtask

    initial begin
        rstn = 1'b0; m_tready = 1'b0; cfg_enable = 1'b0; cfg_mode = 2'd0; err_clr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sd[i] = '0; sv[i] = 1'b0; sl[i] = 1'b0; s_len[i] = FP; s_idx[i] = 0; acc[i] = 0;
            p_valid[i] = 0; len_kind[i] = 0;
        end
        rst_seen = 0; rst_hold = 3; rdy_pct = 100; clr_pct = 0; rst_pm = 0;
        // Reset, then a nominal s0 frame in fixed mode 0.
        phase(0, 1, 100, 0, 0, 0, 100, 0, 0, 45);
        check_eq("A_frames", frame_cnt, 16'(mdl_frames));
        // Round-robin with both sources always valid.
        phase(2, 1, 100, 100, 0, 0, 100, 0, 0, 80);
        // Restart, s1 alone, then s0 joins mid-frame in priority mode.
        rst_hold = 2;
        phase(3, 1, 0, 100, 0, 0, 100, 0, 0, 10);
        phase(3, 1, 100, 100, 0, 0, 100, 0, 0, 50);
        // Short frames from s0.
        phase(0, 1, 100, 0, 10, 0, 100, 0, 0, 60);
        check_eq("D_err_short", err_short, 1'b1);
        // Over-long frames from s0.
        phase(0, 1, 100, 0, 20, 0, 100, 0, 0, 80);
        check_eq("E_err_long", err_long, 1'b1);
        // Park, then clear the sticky flags.
        phase(0, 0, 100, 0, 0, 0, 100, 0, 0, 40);
        phase(0, 0, 100, 0, 0, 0, 100, 100, 0, 1);
        phase(0, 0, 100, 0, 0, 0, 100, 0, 0, 1);
        check_eq("clr_errs", {err_short, err_long}, 2'b00);
        // Random modes, lengths, backpressure, clears and resets.
        for (int ph = 0; ph < 10; ph++) begin
            phase($urandom_range(0, 3), ($urandom_range(0, 9) != 0), 70, 70, 1, 1, 50, 3, 4, 150);
            rst_hold = 1 + (ph % 2);
            phase($urandom_range(0, 3), 1, 80, 60, 1, 1, 50, 2, 0, 150);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_video_source_arbiter.md
Name: axis_video_source_arbiter

Overview:
- Shares the single HDMI AXI4-Stream pixel sink between two video sources, e.g. the frame-buffer reader and the test-pattern generator.
- Frames are delimited by tlast. Grants change only on frame boundaries, so the sink's tlast-based sync always sees whole frames.
- Enforces the nominal frame length. Truncates over-long frames and flags short frames.
- Sits directly in front of the HDMI stream sink in the 25 MHz pixel domain.

Parameters:
- DATA_W, 32, pixel word width ({8'h0,R,G,B}).
- FRAME_PIXELS, 307200, beats per frame (640x480). Benches override it to 16.
- CNT_W, $clog2(FRAME_PIXELS), pixel counter width.

Ports:
- clk_25MHZ  in  1  pixel clock; the only clock.
- rstn  in  1  asynchronous, active-low reset.
- s0_tdata  in  DATA_W  source 0 pixel.
- s0_tvalid  in  1  source 0 valid.
- s0_tlast  in  1  source 0 end of frame.
- s0_tready  out  1  source 0 ready.
- s1_tdata, s1_tvalid, s1_tlast, s1_tready  same as source 0, for source 1.
- m_tdata  out  DATA_W  pixel to the HDMI sink.
- m_tvalid  out  1  valid to the sink.
- m_tlast  out  1  end of frame to the sink.
- m_tready  in  1  sink ready.
- cfg_enable  in  1  arbitration enable.
- cfg_mode  in  2  grant mode: 0 = fixed s0, 1 = fixed s1, 2 = round-robin, 3 = s0 priority.
- err_clr  in  1  clears the sticky error flags.
- grant  out  1  currently or last granted source.
- busy  out  1  a frame is in progress (PASS or DRAIN).
- frame_cnt  out  16  count of completed frames forwarded.
- err_short  out  1  sticky: a frame ended before FRAME_PIXELS beats.
- err_long  out  1  sticky: a frame exceeded FRAME_PIXELS beats.

Behaviour:
- Reset (async assert, sync deassert use) sets:
  - state = IDLE, grant = 0, last_served = 1 (round-robin serves s0 first);
  - pix_cnt = 0, frame_cnt = 0, err_short = err_long = 0;
  - all treadys = 0, m_tvalid = 0, m_tlast = 0, m_tdata = 0.
- A beat is a handshake: tvalid & tready at the rising clock edge.
- State IDLE:
  - All s*_tready = 0; m_tvalid = 0.
  - If cfg_enable = 1, pick a source and register it as grant:
    - mode 0 picks s0 once s0_tvalid = 1;
    - mode 1 picks s1 once s1_tvalid = 1;
    - mode 2 picks the source != last_served if its tvalid = 1, else the other source if its tvalid = 1;
    - mode 3 picks s0 if s0_tvalid = 1, else s1 if s1_tvalid = 1.
  - Once a source is picked, go to PASS. Otherwise stay in IDLE.
  - cfg_mode is sampled only in IDLE; mode changes take effect at the next frame.
- State PASS (zero-latency combinational passthrough):
  - m_tdata/m_tvalid/m_tlast come from the granted source; granted tready = m_tready; other tready = 0.
  - pix_cnt increments on each m beat.
  - Beat with src tlast and pix_cnt == FRAME_PIXELS-1: normal end of frame.
  - Beat with src tlast and pix_cnt < FRAME_PIXELS-1: forward tlast unchanged and set err_short.
  - In both tlast cases: frame_cnt++ (wraps 0xFFFF -> 0), pix_cnt = 0, last_served = grant, go to IDLE.
  - Beat at pix_cnt == FRAME_PIXELS-1 without src tlast:
    - force m_tlast = 1 on that beat;
    - set err_long and increment frame_cnt;
    - pix_cnt = 0, go to DRAIN.
- State DRAIN:
  - Granted tready = 1; m_tvalid = 0; beats are discarded.
  - On the granted source's tlast beat: last_served = grant, go to IDLE.
- There is always at least one IDLE cycle between frames. Grant latency is 1 cycle after the chosen tvalid is seen in IDLE.
- cfg_enable = 0 during PASS or DRAIN: the current frame completes normally, then the block parks in IDLE.
- err_clr = 1 clears err_short/err_long. If an error event happens in the same cycle, the set wins.
- busy = 1 in PASS or DRAIN.
- Reset mid-frame drops the frame immediately. The sink recovers through its own tlast/vsync resync.

Decomposition:
- Package axis_arb_pkg holds:
  - the state enum {IDLE, PASS, DRAIN};
  - mode constants MODE_FIX0, MODE_FIX1, MODE_RR, MODE_PRIO0;
  - the default FRAME_PIXELS.
- One natural sub-module, frame_len_checker: holds pix_cnt and outputs the last_beat, short and long indications.

Test Plan (FRAME_PIXELS = 16):
- Reset, mode 0, s0 sends a 16-beat frame with tlast on beat 15, m_tready = 1 -> 16 m beats, m_tlast on beat 15, frame_cnt = 1, no errors, s1_tready held 0.
- Mode 2, both sources continuously valid, 4 frames -> grant order s0, s1, s0, s1; one IDLE cycle between frames; frame_cnt = 4.
- Mode 3, s1 valid first, s0 becomes valid mid-frame -> s1 frame completes uninterrupted, the next grant goes to s0.
- s0 sends tlast on beat 9 -> m_tlast on beat 9, err_short = 1, frame_cnt++; pulse err_clr -> err_short = 0.
- s0 sends 20 beats with tlast on beat 19 -> m_tlast forced on beat 15, err_long = 1, beats 16-19 consumed with m_tvalid = 0, then IDLE.
- Random m_tready backpressure (50%) plus rstn low mid-frame -> no beat lost or duplicated before reset; all outputs at reset values within the reset cycle.
